// File: rtl/ln_pkg.sv
// Shared definitions for the LN statistics datapath.
// Holds the accumulator width derivations, the saturation helpers and the
// fractional-bit count of the channel reciprocal.
package ln_pkg;

    localparam int unsigned RECIP_FRAC = 16;

    // Signed channel-sum accumulator width.
    function automatic int unsigned sum_w(input int unsigned dat_dw, input int unsigned log2_ch);
        return dat_dw + log2_ch;
    endfunction

    // Unsigned channel square-sum accumulator width.
    function automatic int unsigned sq_w(input int unsigned dat_dw, input int unsigned log2_ch);
        return 2 * dat_dw + log2_ch;
    endfunction

    // Clamp a signed value into the signed range of w bits (w < 64).
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                      input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

    // Clamp an unsigned value into the unsigned range of w bits (w < 64).
    function automatic logic [63:0] sat_unsigned(input logic [63:0] x, input int unsigned w);
        logic [63:0] hi;
        hi = (64'd1 << w) - 64'd1;
        return (x > hi) ? hi : x;
    endfunction

endpackage

// File: rtl/ln_stat_pipe.sv
// Three-stage mean/variance pipe.
//   P1: scale the totals by the channel reciprocal (mean estimate, E[x^2]).
//   P2: saturate the mean to DAT_DW, square it.
//   P3: variance = E[x^2] - mean^2, clamped at 0 and saturated to 2*DAT_DW.
// Ports: clk, rst_n (sync, active-low), flush (drops everything in flight),
//        in_vld/in_last/sum_t/sq_t/recip (totals of a token's final beat),
//        mean/variance/out_vld/out_last (registered results, 3 cycles later).
module ln_stat_pipe
    import ln_pkg::*;
#(
    parameter int unsigned DAT_DW     = 16,
    parameter int unsigned SUM_W      = 28,
    parameter int unsigned SQ_W       = 44,
    parameter int unsigned RECIP_W    = 17,
    parameter int unsigned RECIP_FRAC = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_vld,
    input  logic                    in_last,
    input  logic signed [SUM_W-1:0] sum_t,
    input  logic [SQ_W-1:0]         sq_t,
    input  logic [RECIP_W-1:0]      recip,
    output logic [DAT_DW-1:0]       mean,
    output logic [2*DAT_DW-1:0]     variance,
    output logic                    out_vld,
    output logic                    out_last
);

    // Full product widths; the reciprocal is unsigned, so one guard bit keeps it positive.
    localparam int unsigned MP_W = SUM_W + RECIP_W + 1;
    localparam int unsigned EP_W = SQ_W + RECIP_W;

    logic signed [MP_W-1:0]     m_prod;
    logic [EP_W-1:0]            e_prod;
    logic signed [MP_W-1:0]     m_raw_q;
    logic [EP_W-1:0]            e2_1_q;
    logic                       vld1_q, last1_q;

    logic [DAT_DW-1:0]          m_c;
    logic signed [2*DAT_DW-1:0] m_ext;
    logic [2*DAT_DW-1:0]        msq_c;
    logic [DAT_DW-1:0]          m_q;
    logic [2*DAT_DW-1:0]        msq_q;
    logic [EP_W-1:0]            e2_2_q;
    logic                       vld2_q, last2_q;

    logic [EP_W-1:0]            msq_ext;
    logic [EP_W-1:0]            diff;
    logic [2*DAT_DW-1:0]        v_c;

    always_comb begin
        m_prod = $signed({{(MP_W-SUM_W){sum_t[SUM_W-1]}}, sum_t})
               * $signed({{(MP_W-RECIP_W){1'b0}}, recip});
        e_prod = {{(EP_W-SQ_W){1'b0}}, sq_t} * {{(EP_W-RECIP_W){1'b0}}, recip};
    end

    always_comb begin
        m_c   = DAT_DW'(sat_signed({{(64-MP_W){m_raw_q[MP_W-1]}}, m_raw_q}, DAT_DW));
        m_ext = {{DAT_DW{m_c[DAT_DW-1]}}, m_c};
        msq_c = m_ext * m_ext;
    end

    always_comb begin
        msq_ext = {{(EP_W-2*DAT_DW){1'b0}}, msq_q};
        diff    = '0;
        v_c     = '0;
        if (e2_2_q >= msq_ext) begin
            diff = e2_2_q - msq_ext;
            v_c  = (2*DAT_DW)'(sat_unsigned({{(64-EP_W){1'b0}}, diff}, 2 * DAT_DW));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_raw_q  <= '0;
            e2_1_q   <= '0;
            vld1_q   <= 1'b0;
            last1_q  <= 1'b0;
            m_q      <= '0;
            msq_q    <= '0;
            e2_2_q   <= '0;
            vld2_q   <= 1'b0;
            last2_q  <= 1'b0;
            mean     <= '0;
            variance <= '0;
            out_vld  <= 1'b0;
            out_last <= 1'b0;
        end else begin
            m_raw_q  <= m_prod >>> RECIP_FRAC;
            e2_1_q   <= e_prod >> RECIP_FRAC;
            last1_q  <= in_last;
            m_q      <= m_c;
            msq_q    <= msq_c;
            e2_2_q   <= e2_1_q;
            last2_q  <= last1_q;
            mean     <= m_q;
            variance <= v_c;
            out_last <= last2_q;
            vld1_q   <= in_vld & ~flush;
            vld2_q   <= vld1_q & ~flush;
            out_vld  <= vld2_q & ~flush;
        end
    end

endmodule

// File: rtl/ln_mean_var_acc.sv
// Stage-2 LN accumulator: sums per-beat partial sums / square-sums across all
// channel groups of each token in a W burst, then emits the token's mean and
// variance through ln_stat_pipe.
// Ports: clk, rst_n (sync, active-low), start (new-layer clear), recip_ch,
//        dat_sum/dat_square_sum/dat_sum_vld with burst/group markers
//        Stripe_loop_end/CH_max_now/CH_Stripe_loop_end, results mean/variance
//        with stat_vld/stat_last, and sticky proto_err.
module ln_mean_var_acc
    import ln_pkg::*;
#(
    parameter int unsigned DAT_DW     = 16,
    parameter int unsigned LOG2_TOUT  = 5,
    parameter int unsigned LOG2_CH    = 12,
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned RECIP_W    = 17,
    parameter int unsigned RECIP_FRAC = ln_pkg::RECIP_FRAC
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [RECIP_W-1:0]              recip_ch,
    input  logic signed [DAT_DW+LOG2_TOUT-1:0] dat_sum,
    input  logic                            dat_sum_vld,
    input  logic [2*DAT_DW+LOG2_TOUT-1:0]   dat_square_sum,
    input  logic                            Stripe_loop_end,
    input  logic                            CH_max_now,
    input  logic                            CH_Stripe_loop_end,
    output logic [DAT_DW-1:0]               mean,
    output logic [2*DAT_DW-1:0]             variance,
    output logic                            stat_vld,
    output logic                            stat_last,
    output logic                            proto_err
);

    localparam int unsigned SUM_W = sum_w(DAT_DW, LOG2_CH);
    localparam int unsigned SQ_W  = sq_w(DAT_DW, LOG2_CH);
    localparam int unsigned IN_W  = DAT_DW + LOG2_TOUT;
    localparam int unsigned IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);

    logic signed [SUM_W-1:0] sum_mem [BURST_LEN];
    logic [SQ_W-1:0]         sq_mem  [BURST_LEN];

    logic [IDX_W-1:0]        tok_idx;
    logic                    first_grp;
    logic                    beat;
    logic signed [SUM_W-1:0] sum_t;
    logic [SQ_W-1:0]         sq_t;

    // start wins over a coincident beat.
    assign beat = dat_sum_vld & ~start;

    // The first channel group ignores stale array contents instead of clearing them.
    always_comb begin
        sum_t = (first_grp ? '0 : sum_mem[tok_idx])
              + {{(SUM_W-IN_W){dat_sum[IN_W-1]}}, dat_sum};
        sq_t  = (first_grp ? '0 : sq_mem[tok_idx])
              + {{(SQ_W-2*DAT_DW-LOG2_TOUT){1'b0}}, dat_square_sum};
    end

    always_ff @(posedge clk) begin
        if (beat) begin
            sum_mem[tok_idx] <= sum_t;
            sq_mem[tok_idx]  <= sq_t;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || start) begin
            tok_idx   <= '0;
            first_grp <= 1'b1;
            proto_err <= 1'b0;
        end else if (dat_sum_vld) begin
            if (Stripe_loop_end || tok_idx == LAST_IDX) begin
                tok_idx <= '0;
            end else begin
                tok_idx <= tok_idx + 1'b1;
            end
            if (CH_Stripe_loop_end) begin
                first_grp <= 1'b1;
            end else if (Stripe_loop_end) begin
                first_grp <= 1'b0;
            end
            if ((tok_idx == LAST_IDX && !Stripe_loop_end) ||
                (CH_Stripe_loop_end && !CH_max_now)) begin
                proto_err <= 1'b1;
            end
        end
    end

    ln_stat_pipe #(
        .DAT_DW     (DAT_DW),
        .SUM_W      (SUM_W),
        .SQ_W       (SQ_W),
        .RECIP_W    (RECIP_W),
        .RECIP_FRAC (RECIP_FRAC)
    ) u_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (start),
        .in_vld   (beat & CH_max_now),
        .in_last  (Stripe_loop_end),
        .sum_t    (sum_t),
        .sq_t     (sq_t),
        .recip    (recip_ch),
        .mean     (mean),
        .variance (variance),
        .out_vld  (stat_vld),
        .out_last (stat_last)
    );

endmodule
